// File: rtl/dependency_check_if.sv
// Decode-stage bus: instruction in, decoded controls and forwarding selects out.
// master drives the instruction word, slave is the decode stage.
interface dependency_check_if;
  logic [19:0] ins;
  logic [1:0]  mux_sel_a;
  logic [1:0]  mux_sel_b;
  logic        imm_sel;
  logic [7:0]  Imm;
  logic        mem_en_dec;
  logic        mem_rw_dec;
  logic        mem_mux_sel_dec;
  logic [4:0]  RW_dec;
  logic [4:0]  op_dec;

  modport master (
    output ins,
    input  mux_sel_a, mux_sel_b, imm_sel, Imm,
    input  mem_en_dec, mem_rw_dec, mem_mux_sel_dec,
    input  RW_dec, op_dec
  );

  modport slave (
    input  ins,
    output mux_sel_a, mux_sel_b, imm_sel, Imm,
    output mem_en_dec, mem_rw_dec, mem_mux_sel_dec,
    output RW_dec, op_dec
  );
endinterface

// File: rtl/dependency_check.sv
// Decode and hazard detection for the 8-bit MIPS pipeline.
// Macro FWD_WB_EN enables the two-back (WB) forwarding path.
module dependency_check (
  input  logic                      clk,
  input  logic                      reset,
  dependency_check_if.slave         dc
);

  localparam logic [4:0] OP_LOAD  = 5'b01100;
  localparam logic [4:0] OP_STORE = 5'b01101;

  logic [4:0] op, rw, ra, rb;
  logic       is_load, is_store;
  logic       imm_n, mem_en_n, mem_rw_n, mem_mux_n;
  logic       producer;
  logic [1:0] sel_a_n, sel_b_n;

  logic [4:0] h1;
  logic       h1_v;
`ifdef FWD_WB_EN
  logic [4:0] h2;
  logic       h2_v;
`endif

  assign op       = dc.ins[19:15];
  assign rw       = dc.ins[14:10];
  assign ra       = dc.ins[9:5];
  assign rb       = dc.ins[4:0];
  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_STORE);

  // Opcode class decode: immediate select, memory control, producer flag.
  always_comb begin
    imm_n     = 1'b0;
    mem_en_n  = 1'b0;
    mem_rw_n  = 1'b0;
    mem_mux_n = 1'b0;
    producer  = 1'b1;
    unique case (1'b1)
      is_load: begin
        imm_n     = 1'b1;
        mem_en_n  = 1'b1;
        mem_mux_n = 1'b1;
      end
      is_store: begin
        imm_n    = 1'b1;
        mem_en_n = 1'b1;
        mem_rw_n = 1'b1;
        producer = 1'b0;
      end
      op[4]: imm_n = 1'b1;
      default: ;
    endcase
  end

  // Forwarding selects against in-flight destinations; newest match wins.
  always_comb begin
    sel_a_n = 2'b00;
    sel_b_n = 2'b00;
    if (h1_v && ra == h1) sel_a_n = 2'b01;
`ifdef FWD_WB_EN
    else if (h2_v && ra == h2) sel_a_n = 2'b10;
`endif
    if (h1_v && rb == h1) sel_b_n = 2'b01;
`ifdef FWD_WB_EN
    else if (h2_v && rb == h2) sel_b_n = 2'b10;
`endif
  end

  // Destination history; r0 never becomes a valid forwarding source.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1   <= '0;
      h1_v <= 1'b0;
`ifdef FWD_WB_EN
      h2   <= '0;
      h2_v <= 1'b0;
`endif
    end else begin
      h1   <= rw;
      h1_v <= producer && (rw != 5'd0);
`ifdef FWD_WB_EN
      h2   <= h1;
      h2_v <= h1_v;
`endif
    end
  end

  // Registered decode outputs, one cycle after the instruction edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dc.mux_sel_a       <= '0;
      dc.mux_sel_b       <= '0;
      dc.imm_sel         <= 1'b0;
      dc.Imm             <= '0;
      dc.mem_en_dec      <= 1'b0;
      dc.mem_rw_dec      <= 1'b0;
      dc.mem_mux_sel_dec <= 1'b0;
      dc.RW_dec          <= '0;
      dc.op_dec          <= '0;
    end else begin
      dc.mux_sel_a       <= sel_a_n;
      dc.mux_sel_b       <= sel_b_n;
      dc.imm_sel         <= imm_n;
      dc.Imm             <= {3'b000, rb};
      dc.mem_en_dec      <= mem_en_n;
      dc.mem_rw_dec      <= mem_rw_n;
      dc.mem_mux_sel_dec <= mem_mux_n;
      dc.RW_dec          <= rw;
      dc.op_dec          <= op;
    end
  end

endmodule

// File: tb/tb_dependency_check.sv
// Bench for dependency_check: directed table, async reset cases,
// and random instructions against a queue-based history model.
module tb_dependency_check;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  dependency_check_if dif ();

  dependency_check dut (
    .clk   (clk),
    .reset (rst_n),
    .dc    (dif)
  );

  always #5 clk = ~clk;

`ifdef FWD_WB_EN
  localparam logic [1:0] WB = 2'b10;
`else
  localparam logic [1:0] WB = 2'b00;
`endif

  typedef struct {
    logic [19:0] ins;
    logic [25:0] exp;
    string       nm;
  } vec_t;

  // Most recent destination first; 0 means "nothing forwardable".
  int hist[$];

  function automatic logic [25:0] pk(
    logic [1:0] sa, logic [1:0] sb, logic im, logic [7:0] iv,
    logic en, logic wr, logic mx, logic [4:0] rwd, logic [4:0] opd);
    return {sa, sb, im, iv, en, wr, mx, rwd, opd};
  endfunction

  function automatic logic [1:0] fwd(int r);
    if (r == 0) return 2'b00;
    if (hist.size() > 0 && hist[0] == r) return 2'b01;
`ifdef FWD_WB_EN
    if (hist.size() > 1 && hist[1] == r) return 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic logic [25:0] model(logic [19:0] i);
    int  op, rw, ra, rb;
    bit  ld, st, im;
    op = int'(i[19:15]);
    rw = int'(i[14:10]);
    ra = int'(i[9:5]);
    rb = int'(i[4:0]);
    ld = (op == 12);
    st = (op == 13);
    im = ld || st || (op >= 16);
    return pk(fwd(ra), fwd(rb), im, 8'(rb), ld || st, st, ld,
              5'(rw), 5'(op));
  endfunction

  function automatic void shift(logic [19:0] i);
    int rw;
    rw = (i[19:15] == 5'd13) ? 0 : int'(i[14:10]);
    hist.push_front(rw);
    if (hist.size() > 2) void'(hist.pop_back());
  endfunction

  function automatic logic [25:0] got();
    return {dif.mux_sel_a, dif.mux_sel_b, dif.imm_sel, dif.Imm,
            dif.mem_en_dec, dif.mem_rw_dec, dif.mem_mux_sel_dec,
            dif.RW_dec, dif.op_dec};
  endfunction

  task automatic check(string nm, logic [25:0] act, logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(logic [19:0] i, logic [25:0] exp, string nm);
    dif.ins = i;
    @(posedge clk);
    #1;
    shift(i);
    check(nm, got(), exp);
  endtask

  task automatic async_reset(string nm);
    #2;
    rst_n = 1'b0;
    #1;
    hist.delete();
    check(nm, got(), 26'd0);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t v[9];
  logic [19:0] r_ins;
  logic [25:0] r_exp;

  initial begin
    v[0] = '{20'b00000_00001_00010_00011,
             pk(0, 0, 0, 8'h03, 0, 0, 0, 5'd1, 5'd0), "alu_first"};
    v[1] = '{20'b10100_00100_00001_00000,
             pk(1, 0, 1, 8'h00, 0, 0, 0, 5'd4, 5'h14), "aluimm_fwd_ex"};
    v[2] = '{20'b10100_00100_00001_00000,
             pk(WB, 0, 1, 8'h00, 0, 0, 0, 5'd4, 5'h14), "held_fwd_wb"};
    v[3] = '{20'b00100_00101_00001_00100,
             pk(0, 1, 0, 8'h04, 0, 0, 0, 5'd5, 5'h04), "alu_fwd_b"};
    v[4] = '{20'b01101_00110_00001_00101,
             pk(0, 1, 1, 8'h05, 1, 1, 0, 5'd6, 5'h0d), "store"};
    v[5] = '{20'b00000_00111_00110_00110,
             pk(0, 0, 0, 8'h06, 0, 0, 0, 5'd7, 5'h00), "after_store"};
    v[6] = '{20'b01100_00010_00000_00001,
             pk(0, 0, 1, 8'h01, 1, 0, 1, 5'd2, 5'h0c), "load"};
    v[7] = '{20'b00000_00000_00010_00000,
             pk(1, 0, 0, 8'h00, 0, 0, 0, 5'd0, 5'h00), "load_use_rw0"};
    v[8] = '{20'b00000_00011_00000_00010,
             pk(0, WB, 0, 8'h02, 0, 0, 0, 5'd3, 5'h00), "ra_r0"};

    dif.ins = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", got(), 26'd0);
    rst_n = 1'b1;

    foreach (v[k]) step(v[k].ins, v[k].exp, v[k].nm);

    async_reset("reset_mid");
    step(20'b00000_00100_00011_00011,
         pk(0, 0, 0, 8'h03, 0, 0, 0, 5'd4, 5'h00), "post_reset");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) async_reset("rand_reset");
      case ($urandom_range(0, 3))
        0: r_ins[19:15] = 5'd12;
        1: r_ins[19:15] = 5'd13;
        default: r_ins[19:15] = 5'($urandom);
      endcase
      r_ins[14:10] = 5'($urandom_range(0, 7));
      r_ins[9:5]   = 5'($urandom_range(0, 7));
      r_ins[4:0]   = 5'($urandom_range(0, 7));
      r_exp = model(r_ins);
      step(r_ins, r_exp, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
